// File: rtl/sparse_stream_pkg.sv
// Shared definitions for the sparse-core stream ingress path.
// Provides the stream word geometry, the done-token encoding, the word-class
// enum and the classifier applied to each accepted 17-bit stream word.
package sparse_stream_pkg;

  localparam int          STREAM_W   = 17;
  localparam int          TOKEN_BIT  = 16;
  localparam logic [15:0] DONE_TOKEN = 16'h0100;

  typedef enum logic [1:0] {
    WORD_DATA,
    WORD_STOP,
    WORD_DONE,
    WORD_ILLEGAL
  } word_class_e;

  // Done is tested before stop: 0x0100 has a non-zero upper byte, so the
  // order only matters for readability, but it keeps the rules explicit.
  function automatic word_class_e classify(input logic [STREAM_W-1:0] w);
    word_class_e c;
    if (!w[TOKEN_BIT])                 c = WORD_DATA;
    else if (w[15:0] == DONE_TOKEN)    c = WORD_DONE;
    else if (w[15:8] == 8'h00)         c = WORD_STOP;
    else                               c = WORD_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/stream_fifo_2.sv
// Two-entry FIFO with registered storage, 1-bit read/write pointers and an
// occupancy count.
// Latency: a word pushed into an empty FIFO is on o_rdata the next cycle.
// Backpressure: pushes while full and pops while empty are ignored; i_clr
//   empties the FIFO and overrides push/pop.
// Ports: clk, rst (async, active-high), i_clr, i_push/i_wdata, i_pop,
//   o_rdata (head, or last head seen while empty), o_full, o_empty, o_count.
module stream_fifo_2 #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // While empty the output keeps showing the most recent head rather than a
  // stale slot, so downstream sees a stable value.
  assign o_rdata = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_last   <= '0;
    end else begin
      if (!o_empty) begin
        r_last <= r_mem[r_rd_ptr];
      end
      if (i_clr) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= i_wdata;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

endmodule

// File: rtl/glb_stream_ingress.sv
// Receive stage between a GLB write channel and the sparse core stream inputs:
// buffers words in a 2-entry FIFO, classifies them, counts data words and stop
// tokens, and closes the transfer after the done token.
// Latency: accepted word visible on valid_out/data_out one cycle later when
//   the FIFO was empty; 1 word/cycle sustained with ready_in high.
// Backpressure: ready_out drops when the FIFO is full, once done is seen
//   (until flush), during flush and during reset; never depends on valid_in.
// Ports: clk, rst_n (async, active-HIGH despite its name), flush,
//   data_in/valid_in/ready_out upstream, data_out/is_token_out/valid_out/
//   ready_in downstream, word_count, stop_count, done, err status.
module glb_stream_ingress
  import sparse_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-2:0] data_out,
  output logic                  is_token_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  stop_count,
  output logic                  done,
  output logic                  err
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [1:0]            w_count;
  logic                  w_accept;
  logic                  w_pop;
  word_class_e           w_class;

  logic [CNT_WIDTH-1:0]  r_word_count;
  logic [CNT_WIDTH-1:0]  r_stop_count;
  logic                  r_done;
  logic                  r_err;

  assign w_class   = classify(data_in);
  assign ready_out = !rst_n && !w_full && !r_done && !flush;
  assign w_accept  = valid_in && ready_out;
  assign w_pop     = ready_in && (w_count != 2'd0) && !flush;

  stream_fifo_2 #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst_n),
    .i_clr  (flush),
    .i_push (w_accept),
    .i_wdata(data_in),
    .i_pop  (w_pop),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  assign valid_out    = !w_empty;
  assign data_out     = w_head[DATA_WIDTH-2:0];
  assign is_token_out = w_head[TOKEN_BIT];

  assign word_count = r_word_count;
  assign stop_count = r_stop_count;
  assign done       = r_done;
  assign err        = r_err;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_word_count <= '0;
      r_stop_count <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (flush) begin
      r_word_count <= '0;
      r_stop_count <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      unique case (w_class)
        WORD_DATA: begin
          if (r_word_count != CNT_MAX) r_word_count <= r_word_count + CNT_ONE;
        end
        WORD_STOP: begin
          if (r_stop_count != CNT_MAX) r_stop_count <= r_stop_count + CNT_ONE;
        end
        WORD_DONE:    r_done <= 1'b1;
        WORD_ILLEGAL: r_err  <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_stream_ingress.sv
module tb_glb_stream_ingress;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;   // active-high reset
  logic        flush    = 1'b0;
  logic [16:0] data_in  = '0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic        ready_out;
  logic [15:0] data_out;
  logic        is_token_out;
  logic        valid_out;
  logic [15:0] word_count;
  logic [15:0] stop_count;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  glb_stream_ingress #(.DATA_WIDTH(17), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .is_token_out(is_token_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .word_count  (word_count),
    .stop_count  (stop_count),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of buffered words plus status, updated from the
  // stream rules once per clock.
  logic [16:0] m_q[$];
  logic [16:0] m_last = '0;
  logic [15:0] m_wc   = '0;
  logic [15:0] m_sc   = '0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic        m_acc;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_q.delete();
      m_last = '0;
      m_wc   = '0;
      m_sc   = '0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_acc = valid_in && (m_q.size() < 2) && !m_done && !flush;
      if (m_q.size() > 0) m_last = m_q[0];
      if (flush) begin
        m_q.delete();
        m_wc   = '0;
        m_sc   = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
      end else begin
        if (m_q.size() > 0 && ready_in) void'(m_q.pop_front());
        if (m_acc) begin
          m_q.push_back(data_in);
          if (!data_in[16]) begin
            if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
          end else if (data_in[15:0] == 16'h0100) begin
            m_done = 1'b1;
          end else if (data_in[15:8] == 8'h00) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  logic [16:0] popped[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [16:0] head;
    head = (m_q.size() > 0) ? m_q[0] : m_last;
    chk("ready_out", 32'(ready_out),
        32'(!rst_n && (m_q.size() < 2) && !m_done && !flush));
    chk("valid_out", 32'(valid_out), 32'(m_q.size() > 0));
    chk("data_out", 32'(data_out), 32'(head[15:0]));
    chk("is_token_out", 32'(is_token_out), 32'(head[16]));
    chk("word_count", 32'(word_count), 32'(m_wc));
    chk("stop_count", 32'(stop_count), 32'(m_sc));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic cyc(input logic v, input logic [16:0] d, input logic r, input logic f);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    ready_in = r;
    flush    = f;
    #1;
    check_model();
    if (valid_out && ready_in && !flush && !rst_n) popped.push_back({is_token_out, data_out});
  endtask

  function automatic logic [16:0] rand_word();
    int k;
    k = $urandom_range(0, 15);
    if (k < 9)       return {1'b0, 16'($urandom)};
    else if (k < 13) return {1'b1, 8'h00, 8'($urandom)};
    else if (k == 13) return 17'h10100;
    else             return {1'b1, 8'($urandom_range(2, 255)), 8'($urandom)};
  endfunction

  typedef struct {
    logic        vld;
    logic [16:0] din;
    logic        rdy;
    logic        fl;
    logic        exp_vld;
    logic [15:0] exp_dat;
    logic [15:0] exp_wc;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Expected outputs are those seen in the same cycle the inputs are applied.
    tbl[0]  = '{1'b1, 17'h00001, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b1};
    tbl[1]  = '{1'b1, 17'h00002, 1'b1, 1'b0, 1'b1, 16'h0001, 16'd1, 1'b1};
    tbl[2]  = '{1'b1, 17'h00003, 1'b1, 1'b0, 1'b1, 16'h0002, 16'd2, 1'b1};
    tbl[3]  = '{1'b1, 17'h00004, 1'b1, 1'b0, 1'b1, 16'h0003, 16'd3, 1'b1};
    tbl[4]  = '{1'b1, 17'h00005, 1'b1, 1'b0, 1'b1, 16'h0004, 16'd4, 1'b1};
    tbl[5]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 1'b1, 16'h0005, 16'd5, 1'b1};
    tbl[6]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 1'b0, 16'h0005, 16'd5, 1'b1};
    tbl[7]  = '{1'b0, 17'h00000, 1'b1, 1'b1, 1'b0, 16'h0005, 16'd5, 1'b0};
    tbl[8]  = '{1'b1, 17'h00007, 1'b1, 1'b0, 1'b0, 16'h0005, 16'd0, 1'b1};
    tbl[9]  = '{1'b1, 17'h10000, 1'b1, 1'b0, 1'b1, 16'h0007, 16'd1, 1'b1};
    tbl[10] = '{1'b1, 17'h10001, 1'b1, 1'b0, 1'b1, 16'h0000, 16'd1, 1'b1};
    tbl[11] = '{1'b1, 17'h10100, 1'b1, 1'b0, 1'b1, 16'h0001, 16'd1, 1'b1};
    tbl[12] = '{1'b1, 17'h00009, 1'b1, 1'b0, 1'b1, 16'h0100, 16'd1, 1'b0};
    tbl[13] = '{1'b1, 17'h00009, 1'b1, 1'b0, 1'b0, 16'h0100, 16'd1, 1'b0};

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_token", 32'(is_token_out), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_sc", 32'(stop_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b0;

    // Data stream then stop/done tokens.
    foreach (tbl[i]) begin
      cyc(tbl[i].vld, tbl[i].din, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl%0d_vld", i), 32'(valid_out), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_dat", i), 32'(data_out), 32'(tbl[i].exp_dat));
      chk($sformatf("tbl%0d_wc", i), 32'(word_count), 32'(tbl[i].exp_wc));
      chk($sformatf("tbl%0d_rdy", i), 32'(ready_out), 32'(tbl[i].exp_rdy));
    end
    chk("tok_stop_count", 32'(stop_count), 32'd2);
    chk("tok_done", 32'(done), 32'd1);

    // Backpressure: only two words get in while ready_in is low.
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 17'h00020 + 17'(i), 1'b0, 1'b0);
    chk("bp_wc", 32'(word_count), 32'd2);
    chk("bp_ready", 32'(ready_out), 32'd0);
    popped.delete();
    for (int i = 0; i < 4; i++) cyc(1'b0, 17'h0, 1'b1, 1'b0);
    chk("bp_drain_n", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      chk("bp_drain0", 32'(popped[0]), 32'h00020);
      chk("bp_drain1", 32'(popped[1]), 32'h00021);
    end

    // Illegal token is flagged and still forwarded.
    cyc(1'b0, 17'h0, 1'b1, 1'b1);
    cyc(1'b1, 17'h10203, 1'b0, 1'b0);
    cyc(1'b0, 17'h0, 1'b0, 1'b0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_valid", 32'(valid_out), 32'd1);
    chk("ill_token", 32'(is_token_out), 32'd1);
    chk("ill_data", 32'(data_out), 32'h0203);

    // Flush with a full FIFO and done set.
    cyc(1'b1, 17'h10100, 1'b0, 1'b0);
    cyc(1'b1, 17'h00011, 1'b0, 1'b0);
    chk("full_ready", 32'(ready_out), 32'd0);
    chk("full_done", 32'(done), 32'd1);
    cyc(1'b1, 17'h00011, 1'b1, 1'b1);
    cyc(1'b0, 17'h0, 1'b0, 1'b0);
    chk("fl_valid", 32'(valid_out), 32'd0);
    chk("fl_wc", 32'(word_count), 32'd0);
    chk("fl_sc", 32'(stop_count), 32'd0);
    chk("fl_done", 32'(done), 32'd0);
    chk("fl_err", 32'(err), 32'd0);
    chk("fl_ready", 32'(ready_out), 32'd1);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 15; i++)
      cyc(1'($urandom_range(0, 1)), {1'b0, 16'($urandom)}, 1'($urandom_range(0, 1)), 1'b0);
    cyc(1'b1, 17'h0ABCD, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mrst_ready", 32'(ready_out), 32'd0);
    chk("mrst_valid", 32'(valid_out), 32'd0);
    chk("mrst_data", 32'(data_out), 32'd0);
    chk("mrst_wc", 32'(word_count), 32'd0);
    check_model();
    cyc(1'b1, 17'h00055, 1'b1, 1'b0);
    cyc(1'b0, 17'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    popped.delete();
    cyc(1'b1, 17'h000A1, 1'b1, 1'b0);
    cyc(1'b1, 17'h000A2, 1'b1, 1'b0);
    cyc(1'b1, 17'h000A3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 17'h0, 1'b1, 1'b0);
    chk("post_rst_n", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("post_rst0", 32'(popped[0]), 32'h000A1);
      chk("post_rst1", 32'(popped[1]), 32'h000A2);
      chk("post_rst2", 32'(popped[2]), 32'h000A3);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), rand_word(),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
